// File: rtl/regfile_sliced.sv
// Register file with a narrow write port: each accepted write is extended once,
// then streamed into the destination register one slice per clock.
module regfile_sliced #(
   parameter int XLEN    = 32,
   parameter int SLICE_W = 16,
   parameter int NREGS   = 32,
   localparam int NSLICE = XLEN / SLICE_W,
   localparam int AW     = $clog2(NREGS),
   localparam int SW     = (NSLICE > 1) ? $clog2(NSLICE) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [AW-1:0]      rs1_i,
   input  logic [AW-1:0]      rs2_i,
   input  logic [SW-1:0]      rs2_slice_i,
   output logic [XLEN-1:0]    rs1_do,
   output logic [SLICE_W-1:0] rs2_do,
   input  logic               wr_valid_i,
   output logic               wr_ready_o,
   input  logic [AW-1:0]      wr_rd_i,
   input  logic [XLEN-1:0]    wr_data_i,
   input  logic [1:0]         wr_size_i,
   input  logic               wr_ext_i,
   output logic               busy_o,
   output logic               wr_done_o,
   output logic               hazard_rs1_o,
   output logic               hazard_rs2_o
);

   typedef enum logic {IDLE, WRITE} state_t;

   localparam logic [SW-1:0] LAST_CNT = SW'(NSLICE - 1);

   logic [NSLICE-1:0][SLICE_W-1:0] mem [NREGS];

   state_t                         state_q, state_d;
   logic [SW-1:0]                  cnt_q, cnt_d;
   logic [AW-1:0]                  rd_q;
   logic [NSLICE-1:0][SLICE_W-1:0] ev_q;
   logic                           done_q;
   logic                           accept;
   logic                           last_slice;

   function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] d,
                                              input logic [1:0] sz,
                                              input logic sx);
      logic [XLEN-1:0] r;
      r = d;
      case (sz)
         2'b00:   r = {{(XLEN-8){sx & d[7]}}, d[7:0]};
         2'b01:   r = {{(XLEN-16){sx & d[15]}}, d[15:0]};
         2'b10:   r = d;
         default: r = {{(XLEN-1){1'b0}}, d[0]};
      endcase
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // A new request may be taken on the same edge that writes the last slice.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = WRITE;
               cnt_d   = '0;
            end
         end
         WRITE: begin
            if (last_slice) begin
               state_d = accept ? WRITE : IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + SW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      busy_o     = (state_q == WRITE);
      last_slice = busy_o && (cnt_q == LAST_CNT);
      wr_ready_o = !busy_o || (cnt_q == LAST_CNT);
      accept     = wr_valid_i && wr_ready_o;
   end

   // Register 0 is never written, so it keeps its reset value of zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREGS; r++) begin
            mem[r] <= '0;
         end
         rd_q   <= '0;
         ev_q   <= '0;
         done_q <= 1'b0;
      end else begin
         if (busy_o && (rd_q != '0)) begin
            mem[rd_q][cnt_q] <= ev_q[cnt_q];
         end
         if (accept) begin
            rd_q <= wr_rd_i;
            ev_q <= extend(wr_data_i, wr_size_i, wr_ext_i);
         end
         done_q <= last_slice;
      end
   end

   assign wr_done_o    = done_q;
   assign rs1_do       = (rs1_i == '0) ? '0 : mem[rs1_i];
   assign rs2_do       = (rs2_i == '0) ? '0 : mem[rs2_i][rs2_slice_i];
   assign hazard_rs1_o = busy_o && (rs1_i == rd_q) && (rd_q != '0);
   assign hazard_rs2_o = busy_o && (rs2_i == rd_q) && (rd_q != '0);

endmodule

// File: tb/tb_regfile_sliced.sv
// Bench for regfile_sliced: default 32/16/32 instance plus 8-bit-slice/RV32E
// and full-width-slice instances.
module tb_regfile_sliced;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic [4:0]  rs1, rs2, wr_rd;
   logic        rs2_slice;
   logic [31:0] rs1_do, wr_data;
   logic [15:0] rs2_do;
   logic [1:0]  wr_size;
   logic        wr_valid, wr_ready, wr_ext, busy, wr_done, hz1, hz2;

   logic [3:0]  s8_rs1, s8_rs2, s8_rd;
   logic [1:0]  s8_slice, s8_size;
   logic [31:0] s8_rs1_do, s8_data;
   logic [7:0]  s8_rs2_do;
   logic        s8_valid, s8_ready, s8_ext, s8_busy, s8_done, s8_hz1, s8_hz2;

   logic [4:0]  w_rs1, w_rs2, w_rd;
   logic        w_slice, w_ext;
   logic [1:0]  w_size;
   logic [31:0] w_rs1_do, w_rs2_do, w_data;
   logic        w_valid, w_ready, w_busy, w_done, w_hz1, w_hz2;

   regfile_sliced dut (
      .clk(clk), .rst(rst), .rs1_i(rs1), .rs2_i(rs2), .rs2_slice_i(rs2_slice),
      .rs1_do(rs1_do), .rs2_do(rs2_do), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
      .wr_rd_i(wr_rd), .wr_data_i(wr_data), .wr_size_i(wr_size), .wr_ext_i(wr_ext),
      .busy_o(busy), .wr_done_o(wr_done), .hazard_rs1_o(hz1), .hazard_rs2_o(hz2)
   );

   regfile_sliced #(.XLEN(32), .SLICE_W(8), .NREGS(16)) dut8 (
      .clk(clk), .rst(rst), .rs1_i(s8_rs1), .rs2_i(s8_rs2), .rs2_slice_i(s8_slice),
      .rs1_do(s8_rs1_do), .rs2_do(s8_rs2_do), .wr_valid_i(s8_valid), .wr_ready_o(s8_ready),
      .wr_rd_i(s8_rd), .wr_data_i(s8_data), .wr_size_i(s8_size), .wr_ext_i(s8_ext),
      .busy_o(s8_busy), .wr_done_o(s8_done), .hazard_rs1_o(s8_hz1), .hazard_rs2_o(s8_hz2)
   );

   regfile_sliced #(.XLEN(32), .SLICE_W(32), .NREGS(32)) dut32 (
      .clk(clk), .rst(rst), .rs1_i(w_rs1), .rs2_i(w_rs2), .rs2_slice_i(w_slice),
      .rs1_do(w_rs1_do), .rs2_do(w_rs2_do), .wr_valid_i(w_valid), .wr_ready_o(w_ready),
      .wr_rd_i(w_rd), .wr_data_i(w_data), .wr_size_i(w_size), .wr_ext_i(w_ext),
      .busy_o(w_busy), .wr_done_o(w_done), .hazard_rs1_o(w_hz1), .hazard_rs2_o(w_hz2)
   );

   typedef struct {
      logic [4:0]  rd;
      logic [1:0]  size;
      logic        ext;
      logic [31:0] data;
      logic [31:0] expected;
   } vec_t;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] value;
   } sb_t;

   vec_t vecs[8];
   sb_t  sb_q[$];

   int checks = 0;
   int passed = 0;
   int idle_not_ready = 0;
   int done_pulses = 0;

   always @(negedge clk) begin
      if (rst === 1'b0 && busy === 1'b0 && wr_ready !== 1'b1) idle_not_ready++;
      if (wr_done === 1'b1) done_pulses++;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // Drives one request from IDLE; it is accepted on the next rising edge.
   task automatic applyStimulus(input logic [4:0] rd, input logic [1:0] size,
                                input logic ext, input logic [31:0] data,
                                input logic [31:0] expected);
      sb_t s;
      @(negedge clk);
      wr_valid = 1'b1;
      wr_rd    = rd;
      wr_size  = size;
      wr_ext   = ext;
      wr_data  = data;
      @(posedge clk);
      s.rd    = rd;
      s.value = expected;
      sb_q.push_back(s);
      @(negedge clk);
      wr_valid = 1'b0;
      wr_data  = 32'h0;
   endtask

   task automatic waitDone(input int budget);
      int n;
      sb_t s;
      n = 0;
      while (wr_done !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (wr_done !== 1'b1) begin
         checks++;
         $display("[TB] FAIL wr_done timeout: got %0b after %0d cycles, expected 1", wr_done, n);
      end else if (sb_q.size() > 0) begin
         s = sb_q.pop_front();
         rs1 = s.rd;
         #1;
         checkOutput($sformatf("readback x%0d", s.rd), rs1_do, s.value);
      end
   endtask

   initial begin
      logic [31:0] exp8;
      int base;

      rst = 1'b1;
      {rs1, rs2, rs2_slice, wr_rd, wr_data, wr_size, wr_ext, wr_valid} = '0;
      {s8_rs1, s8_rs2, s8_slice, s8_rd, s8_data, s8_size, s8_ext, s8_valid} = '0;
      {w_rs1, w_rs2, w_slice, w_rd, w_data, w_size, w_ext, w_valid} = '0;

      vecs[0] = '{5'd1,  2'b00, 1'b1, 32'h12345680, 32'hFFFFFF80};
      vecs[1] = '{5'd2,  2'b00, 1'b0, 32'h12345680, 32'h00000080};
      vecs[2] = '{5'd4,  2'b01, 1'b1, 32'h00008001, 32'hFFFF8001};
      vecs[3] = '{5'd6,  2'b01, 1'b0, 32'h00008001, 32'h00008001};
      vecs[4] = '{5'd1,  2'b11, 1'b1, 32'hFFFFFFFE, 32'h00000000};
      vecs[5] = '{5'd2,  2'b11, 1'b1, 32'h00000003, 32'h00000001};
      vecs[6] = '{5'd10, 2'b10, 1'b0, 32'h89ABCDEF, 32'h89ABCDEF};
      vecs[7] = '{5'd11, 2'b00, 1'b1, 32'h0000007F, 32'h0000007F};

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      for (int r = 0; r < 32; r++) begin
         rs1 = 5'(r);
         #1;
         checkOutput($sformatf("reset x%0d", r), rs1_do, 32'h0);
      end
      rs1 = 5'd0;
      #1;
      checkOutput("reset rs2_do", {16'h0, rs2_do}, 32'h0);
      checkOutput("reset wr_ready", {31'h0, wr_ready}, 32'h1);
      checkOutput("reset busy", {31'h0, busy}, 32'h0);
      checkOutput("reset wr_done", {31'h0, wr_done}, 32'h0);
      checkOutput("reset hazards", {30'h0, hz1, hz2}, 32'h0);

      // Word write with an input change after accept
      @(negedge clk);
      wr_valid = 1'b1; wr_rd = 5'd5; wr_size = 2'b10; wr_ext = 1'b0; wr_data = 32'hDEADBEEF;
      rs1 = 5'd5; rs2 = 5'd5; rs2_slice = 1'b0;
      @(posedge clk);
      @(negedge clk);
      wr_valid = 1'b0; wr_data = 32'h0; wr_rd = 5'd7;
      #1;
      checkOutput("word T busy", {31'h0, busy}, 32'h1);
      checkOutput("word T ready", {31'h0, wr_ready}, 32'h0);
      checkOutput("word T hazard rs2", {31'h0, hz2}, 32'h1);
      checkOutput("word T rs1_do", rs1_do, 32'h0);
      @(negedge clk);
      #1;
      checkOutput("word T+1 rs1_do", rs1_do, 32'h0000BEEF);
      checkOutput("word T+1 hazard rs1", {31'h0, hz1}, 32'h1);
      checkOutput("word T+1 ready", {31'h0, wr_ready}, 32'h1);
      checkOutput("word T+1 rs2_do", {16'h0, rs2_do}, 32'h0000BEEF);
      @(negedge clk);
      #1;
      checkOutput("word T+2 rs1_do", rs1_do, 32'hDEADBEEF);
      checkOutput("word T+2 busy", {31'h0, busy}, 32'h0);
      checkOutput("word T+2 done", {31'h0, wr_done}, 32'h1);
      checkOutput("word T+2 hazard rs1", {31'h0, hz1}, 32'h0);
      rs2_slice = 1'b1;
      #1;
      checkOutput("word rs2 slice1", {16'h0, rs2_do}, 32'h0000DEAD);
      rs1 = 5'd7;
      #1;
      checkOutput("word x7 untouched", rs1_do, 32'h0);
      @(negedge clk);
      #1;
      checkOutput("word T+3 done", {31'h0, wr_done}, 32'h0);

      // Extension table through the scoreboard
      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].rd, vecs[i].size, vecs[i].ext, vecs[i].data, vecs[i].expected);
         waitDone(8);
      end

      // x0 write followed with no bubble by x3
      @(negedge clk);
      wr_valid = 1'b1; wr_rd = 5'd0; wr_size = 2'b10; wr_ext = 1'b0; wr_data = 32'hFFFFFFFF;
      rs1 = 5'd0;
      @(posedge clk);
      @(negedge clk);
      wr_rd = 5'd3; wr_data = 32'h0000CAFE;
      #1;
      checkOutput("b2b cnt0 ready", {31'h0, wr_ready}, 32'h0);
      checkOutput("b2b x0 hazard", {31'h0, hz1}, 32'h0);
      @(negedge clk);
      #1;
      checkOutput("b2b cnt1 ready", {31'h0, wr_ready}, 32'h1);
      @(negedge clk);
      wr_valid = 1'b0;
      #1;
      checkOutput("b2b T+2 busy", {31'h0, busy}, 32'h1);
      checkOutput("b2b x0 done", {31'h0, wr_done}, 32'h1);
      checkOutput("b2b x0 reads 0", rs1_do, 32'h0);
      rs1 = 5'd3;
      #1;
      checkOutput("b2b x3 hazard", {31'h0, hz1}, 32'h1);
      @(negedge clk);
      @(negedge clk);
      #1;
      checkOutput("b2b x3 value", rs1_do, 32'h0000CAFE);
      checkOutput("b2b x3 done", {31'h0, wr_done}, 32'h1);
      checkOutput("b2b idle", {31'h0, busy}, 32'h0);
      checkOutput("ready low in IDLE count", 32'(idle_not_ready), 32'h0);

      // Reset interrupting a sequence
      @(negedge clk);
      base = done_pulses;
      wr_valid = 1'b1; wr_rd = 5'd9; wr_size = 2'b10; wr_data = 32'hAAAA5555;
      rs1 = 5'd9;
      @(posedge clk);
      @(negedge clk);
      wr_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("rst mid x9", rs1_do, 32'h0);
      checkOutput("rst mid busy", {31'h0, busy}, 32'h0);
      checkOutput("rst mid ready", {31'h0, wr_ready}, 32'h1);
      repeat (4) @(negedge clk);
      #1;
      checkOutput("rst mid x9 later", rs1_do, 32'h0);
      checkOutput("rst mid done pulses", 32'(done_pulses - base), 32'h0);

      // SLICE_W=8, NREGS=16
      exp8 = 32'h11223344;
      @(negedge clk);
      s8_valid = 1'b1; s8_rd = 4'd15; s8_size = 2'b10; s8_data = exp8;
      s8_rs1 = 4'd15; s8_rs2 = 4'd15;
      @(posedge clk);
      @(negedge clk);
      s8_valid = 1'b0; s8_data = 32'h0;
      #1;
      checkOutput("s8 busy", {31'h0, s8_busy}, 32'h1);
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("s8 ready cnt%0d", k), {31'h0, s8_ready}, (k == 3) ? 32'h1 : 32'h0);
         @(negedge clk);
         s8_slice = 2'(k);
         #1;
         checkOutput($sformatf("s8 slice%0d", k), {24'h0, s8_rs2_do}, {24'h0, exp8[k*8 +: 8]});
         if (k < 3) begin
            s8_slice = 2'(k + 1);
            #1;
            checkOutput($sformatf("s8 slice%0d pending", k + 1), {24'h0, s8_rs2_do}, 32'h0);
         end
      end
      checkOutput("s8 full", s8_rs1_do, exp8);
      checkOutput("s8 done", {31'h0, s8_done}, 32'h1);
      checkOutput("s8 busy end", {31'h0, s8_busy}, 32'h0);

      // SLICE_W=32: single write cycle
      @(negedge clk);
      w_valid = 1'b1; w_rd = 5'd7; w_size = 2'b10; w_data = 32'h12345678; w_rs1 = 5'd7;
      @(posedge clk);
      @(negedge clk);
      w_valid = 1'b0; w_data = 32'h0;
      #1;
      checkOutput("w32 busy", {31'h0, w_busy}, 32'h1);
      checkOutput("w32 ready", {31'h0, w_ready}, 32'h1);
      @(negedge clk);
      #1;
      checkOutput("w32 value", w_rs1_do, 32'h12345678);
      checkOutput("w32 done", {31'h0, w_done}, 32'h1);
      checkOutput("w32 busy end", {31'h0, w_busy}, 32'h0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/regfile_sliced.md
REGFILE_SLICED -- requirements
Module: regfile_sliced

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the architectural register width.
REQ-002 The block SHALL have parameter SLICE_W, default 16, giving the write-slice width; legal values are 8, 16 and 32; NSLICE = XLEN/SLICE_W.
REQ-003 The block SHALL have parameter NREGS, default 32, giving the register count; legal values are 16 (RV32E) and 32; AW = log2(NREGS).
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 The block SHALL have these ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- rs1_i  in  AW  read address 1.
- rs2_i  in  AW  read address 2.
- rs2_slice_i  in  max(1,log2(NSLICE))  slice select for read port 2.
- rs1_do  out  XLEN  full word of rs1_i.
- rs2_do  out  SLICE_W  selected slice of rs2_i.
- wr_valid_i  in  1  write request.
- wr_ready_o  out  1  write accept.
- wr_rd_i  in  AW  destination register.
- wr_data_i  in  XLEN  raw write data.
- wr_size_i  in  2  size: 00=B, 01=H, 10=W, 11=BIT.
- wr_ext_i  in  1  extension: 0=zero, 1=sign.
- busy_o  out  1  write sequence in progress.
- wr_done_o  out  1  one-cycle pulse after the last slice is written.
- hazard_rs1_o  out  1  rs1_i matches the register being written.
- hazard_rs2_o  out  1  rs2_i matches the register being written.

Function
REQ-006 Reads SHALL be combinational from the array: rs1_do is the concatenation of slices NSLICE-1..0; rs2_do is slice rs2_slice_i; there is no write bypass.
REQ-007 Register 0 SHALL always read zero; writes to it are accepted and sequenced but never change the array.
REQ-008 On accept (wr_valid_i and wr_ready_o at a rising edge), the block SHALL latch wr_rd_i and an extended value EV:
- B: data[7:0] extended.
- H: data[15:0] extended.
- W: data unchanged.
- BIT: {0…, data[0]}; wr_ext_i is ignored for BIT.
REQ-009 The FSM SHALL have two states, IDLE and WRITE, plus a slice counter cnt of width log2(NSLICE), minimum 1 bit.
- IDLE: on accept, go to WRITE with cnt=0.
- WRITE: at each edge, write EV slice cnt into the latched rd; then cnt++.
- WRITE, after slice NSLICE-1: go to IDLE, or restart WRITE with cnt=0 if a new request is accepted on the same edge.
REQ-010 For a request accepted at edge T, slice k SHALL be written at edge T+1+k, and the full value SHALL be visible on reads after edge T+NSLICE.
REQ-011 wr_ready_o SHALL be 1 in IDLE, and 1 in WRITE only when cnt=NSLICE-1, allowing back-to-back writes with no bubble; it is 0 otherwise.
REQ-012 busy_o SHALL be 1 exactly in WRITE.
REQ-013 wr_done_o SHALL be 1 for the single cycle after the edge that writes the last slice.
REQ-014 hazard_rs1_o SHALL equal busy_o and (rs1_i == latched rd) and (latched rd != 0); hazard_rs2_o is defined the same way for rs2_i.
REQ-015 With SLICE_W = XLEN (NSLICE = 1), each write SHALL complete in one WRITE cycle, and wr_ready_o SHALL stay 1 throughout.
REQ-016 Input changes after accept SHALL NOT affect an in-flight sequence.
REQ-017 Addresses at or above NREGS SHALL NOT be presented; behaviour for them is don't-care.

Reset
REQ-018 When rst is high at a rising edge:
- every register slice becomes 0;
- FSM goes to IDLE; cnt, latched rd and EV become 0;
- wr_done_o becomes 0.
REQ-019 rst SHALL take priority over accept and over slice writes; a sequence interrupted by reset is abandoned, with no slice written on that edge.
REQ-020 After reset, the outputs SHALL be: wr_ready_o=1, busy_o=0, wr_done_o=0, hazard_rs1_o=0, hazard_rs2_o=0, rs1_do=0, rs2_do=0.

Verification
REQ-021 The bench SHALL cover these scenarios, at the default parameters unless stated:
- Reset: assert rst for 2 cycles -> every register reads 0x00000000, wr_ready_o=1, busy_o=0.
- Word write: W, x5, 0xDEADBEEF accepted at T -> after T+1 rs1_do(x5)=0x0000BEEF and hazard_rs1_o=1; after T+2 rs1_do=0xDEADBEEF, busy_o=0, wr_done_o pulses once.
- Extension: B sign 0x12345680 -> 0xFFFFFF80; B zero -> 0x00000080; H sign 0x00008001 -> 0xFFFF8001; BIT 0xFFFFFFFE -> 0x00000000; BIT 0x00000003 -> 0x00000001.
- x0 and back-to-back: W x0 0xFFFFFFFF followed with no bubble by W x3 0x0000CAFE (accepted while cnt=1) -> x0 reads 0; x3=0x0000CAFE after 4 edges total; wr_ready_o never low in IDLE.
- Reset mid-sequence: W x9 0xAAAA5555 accepted, rst on the next edge -> x9=0, FSM IDLE, wr_done_o never pulses.
- Parameters SLICE_W=8, NREGS=16: W x15 0x11223344 -> 4 write cycles, slices 0x44, 0x33, 0x22, 0x11 appear in order; SLICE_W=32 -> 1 write cycle.
